// File: rtl/seven_seg_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_scan_pkg: segment decode table, blank/dash patterns and the    |
// | default refresh divider shared by the scanned display driver.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seven_seg_scan_pkg;

   localparam int unsigned C_REFRESH_DIV_DEFAULT = 100000;

   // Patterns are {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
   localparam logic [6:0] C_SEG_DASH  = 7'b0111111;

   // Entry k of the packed array is the pattern for code k (listed 15 down to 0)
   localparam logic [15:0][6:0] C_SEG_LUT = {
      C_SEG_DASH, C_SEG_DASH, C_SEG_DASH,
      C_SEG_DASH, C_SEG_DASH, C_SEG_DASH,
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_bcd_to_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_to_seg: 4-bit code to active-low seven-segment pattern.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_to_seg
   import seven_seg_scan_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = C_SEG_LUT[code];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seven_seg_scan: multiplexed BCD display driver with overflow dp latch.   |
// | Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seven_seg_scan
   import seven_seg_scan_pkg::*;
#(
   parameter int NDIGITS     = 4,
   parameter int REFRESH_DIV = C_REFRESH_DIV_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NDIGITS*4-1:0] bcd,
   input  logic                 ovf,
   input  logic                 ovf_clr,
   output logic [6:0]           seg,
   output logic                 dp,
   output logic [NDIGITS-1:0]   anode
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NDIGITS - 1);

   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [NDIGITS*4-1:0] r_snap;
   logic                 r_ovf;
   logic                 w_tick;
   logic [3:0]           w_code;
   logic [6:0]           w_dec;
   logic [6:0]           w_seg_nxt;
   logic [NDIGITS-1:0]   w_anode_nxt;

   assign w_tick = (r_cnt == C_CNT_LAST);

   // Snapshot only reloads at the end of a full scan so one scan never mixes values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_idx  <= '0;
         r_snap <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_tick) begin
            r_cnt <= '0;
            if (r_idx == C_IDX_LAST) begin
               r_idx  <= '0;
               r_snap <= bcd;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (ovf)
            r_ovf <= 1'b1;
         else if (ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   assign w_code = 4'(r_snap >> {r_idx, 2'b00});

   bcd_to_seg u_bcd_to_seg (
      .code (w_code),
      .seg  (w_dec)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Digit is a leading zero when it and everything above it is zero
   logic [NDIGITS*4-1:0] w_upper;
   assign w_upper   = r_snap >> {r_idx, 2'b00};
   assign w_seg_nxt = ((r_idx != '0) && (w_upper == '0)) ? C_SEG_BLANK : w_dec;
`else
   assign w_seg_nxt = w_dec;
`endif

   assign w_anode_nxt = ~(NDIGITS'(1) << r_idx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         anode <= '1;
         seg   <= C_SEG_BLANK;
         dp    <= 1'b1;
      end else begin
         anode <= w_anode_nxt;
         seg   <= w_seg_nxt;
         dp    <= ~r_ovf;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seven_seg_scan: randomized bench for seven_seg_scan (NDIGITS=4,       |
// | REFRESH_DIV=4) against a slot/scan-level reference model.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] bcd = '0;
   logic        ovf = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  anode;

   int checks = 0;
   int errors = 0;

   // Model: cycles into the current slot, displayed digit, snapshot, overflow flag
   int          m_cnt;
   int          m_idx;
   int          m_ovf;
   logic [15:0] m_snap;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_anode;

   always #5 clk = ~clk;

   seven_seg_scan #(.NDIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk     (clk),
      .rst     (rst),
      .bcd     (bcd),
      .ovf     (ovf),
      .ovf_clr (ovf_clr),
      .seg     (seg),
      .dp      (dp),
      .anode   (anode)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input int code);
      case (code)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_idx   = 0;
      m_ovf   = 0;
      m_snap  = '0;
      e_anode = 4'hF;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".anode"}, 32'(anode), 32'(e_anode));
      check({tag, ".seg"},   32'(seg),   32'(e_seg));
      check({tag, ".dp"},    32'(dp),    32'(e_dp));
   endtask

   // Called at a falling edge: apply inputs, let one rising edge pass, check
   task automatic cycle(input logic [15:0] b, input logic o, input logic c, input string tag);
      int digit;
      bcd     = b;
      ovf     = o;
      ovf_clr = c;
      @(posedge clk);
      digit   = int'((m_snap >> (4 * m_idx)) % 16);
      e_anode = 4'(15 - (1 << m_idx));
      e_seg   = ref_seg(digit);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && (m_snap >> (4 * m_idx)) == 0)
         e_seg = 7'h7F;
`endif
      e_dp = (m_ovf == 0);
      if (o)
         m_ovf = 1;
      else if (c)
         m_ovf = 0;
      if (m_cnt == RD - 1) begin
         m_cnt = 0;
         if (m_idx == ND - 1)
            m_snap = b;
         m_idx = (m_idx + 1) % ND;
      end else begin
         m_cnt = m_cnt + 1;
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic rand_bcd(output logic [15:0] b);
      for (int k = 0; k < 4; k++)
         b[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0)
         b[15:8] = 8'h00;
   endtask

   initial begin
      logic [15:0] rb;
      int n;
      model_reset();
      rst = 1'b0;
      #12;
      check_outputs("reset_hold");
      @(negedge clk);
      check_outputs("reset_hold_edge");
      rst = 1'b1;

      // First edge after release shows digit 0 of the zero snapshot
      cycle(16'h1234, 1'b0, 1'b0, "first_edge");
      check("first_edge.anode_val", 32'(anode), 32'(4'b1110));
      check("first_edge.seg_val",   32'(seg),   32'(7'b1000000));

      for (int i = 0; i < 40; i++) cycle(16'h1234, 1'b0, 1'b0, "scan_1234");

      // Change input while index is 1 mid-scan
      n = 0;
      while (m_idx != 1 && n < 64) begin
         cycle(16'h1234, 1'b0, 1'b0, "wait_idx1");
         n++;
      end
      check("wait_idx1.reached", 32'(m_idx), 32'd1);
      for (int i = 0; i < 40; i++) cycle(16'h5678, 1'b0, 1'b0, "swap_5678");

      for (int i = 0; i < 36; i++) cycle(16'h0042, 1'b0, 1'b0, "lead_0042");
      for (int i = 0; i < 36; i++) cycle(16'h0000, 1'b0, 1'b0, "lead_0000");
      for (int i = 0; i < 36; i++) cycle(16'h0A30, 1'b0, 1'b0, "dash_0a30");

      // Overflow latch: set, hold, simultaneous set/clear, clear
      cycle(16'h0A30, 1'b1, 1'b0, "ovf_set");
      for (int i = 0; i < 10; i++) cycle(16'h0A30, 1'b0, 1'b0, "ovf_hold");
      cycle(16'h0A30, 1'b1, 1'b1, "ovf_both");
      for (int i = 0; i < 6; i++) cycle(16'h0A30, 1'b0, 1'b0, "ovf_both_hold");
      check("ovf_both.dp_low", 32'(dp), 32'd0);
      cycle(16'h0A30, 1'b0, 1'b1, "ovf_clr");
      for (int i = 0; i < 6; i++) cycle(16'h0A30, 1'b0, 1'b0, "ovf_cleared");
      check("ovf_cleared.dp_high", 32'(dp), 32'd1);

      // Randomized traffic: bcd changes every cycle, sparse ovf/ovf_clr pulses
      for (int i = 0; i < 600; i++) begin
         rand_bcd(rb);
         cycle(rb, ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0), "random");
      end

      // Asynchronous reset in the middle of the slot for index 2
      n = 0;
      while (!(m_idx == 2 && m_cnt == 1) && n < 64) begin
         cycle(16'h4321, 1'b1, 1'b0, "wait_idx2");
         n++;
      end
      check("wait_idx2.reached", 32'(m_idx), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      @(negedge clk);
      check_outputs("async_reset_hold");
      rst = 1'b1;
      for (int i = 0; i < 36; i++) cycle(16'h9999, 1'b0, 1'b0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
